// File: rtl/seven_seg_pkg.sv
// Shared segment codes, conversion FSM state type and helpers for the 7-segment scan driver.
package seven_seg_pkg;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_t;

   // Common-anode, active-low; bit7 = DP (off), bits6:0 = g..a
   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
      logic [7:0] code;
      case (d)
         4'd0:    code = SEG_DIGIT[0];
         4'd1:    code = SEG_DIGIT[1];
         4'd2:    code = SEG_DIGIT[2];
         4'd3:    code = SEG_DIGIT[3];
         4'd4:    code = SEG_DIGIT[4];
         4'd5:    code = SEG_DIGIT[5];
         4'd6:    code = SEG_DIGIT[6];
         4'd7:    code = SEG_DIGIT[7];
         4'd8:    code = SEG_DIGIT[8];
         4'd9:    code = SEG_DIGIT[9];
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock, BIN_WIDTH steps per value.
//
// state  | meaning
// IDLE   | waiting for start; captures bin on start
// CONV   | one add-3/shift step per cycle, BIN_WIDTH cycles
// COMMIT | bcd valid, done pulses for one cycle
module bin2bcd_seq
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_WIDTH  = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [BIN_WIDTH-1:0]    bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(BIN_WIDTH + 1);

   conv_state_t          state_q, state_d;
   logic [BIN_WIDTH-1:0] sh_q, sh_d;
   logic [BW-1:0]        acc_q, acc_d, acc_adj;
   logic [CW-1:0]        cnt_q, cnt_d;

   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin;
               acc_d   = '0;
               cnt_d   = CW'(BIN_WIDTH - 1);
               state_d = CONV;
            end
         end
         CONV: begin
            acc_d = {acc_adj[BW-2:0], sh_q[BIN_WIDTH-1]};
            sh_d  = sh_q << 1;
            if (cnt_q == '0) state_d = COMMIT;
            else             cnt_d   = cnt_q - CW'(1);
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == COMMIT);
   assign bcd  = acc_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with sequential BCD conversion.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_WIDTH  = 14,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_WIDTH-1:0]  bin_in,
   input  logic                  load,
   output logic                  busy,
   input  logic                  enable,
   input  logic [NUM_DIGITS-1:0] dp_in,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [7:0]            seg_n,
   output logic                  overflow
);

   localparam int          IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int          PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned OVF_LIMIT = pow10(NUM_DIGITS);

   logic                    conv_busy, conv_done, accept;
   logic [4*NUM_DIGITS-1:0] conv_bcd;

   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
   logic                    ovf_q, ovf_d, ovf_pend_q, ovf_pend_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [7:0]              seg_q, seg_d;

   logic [3:0]              cur_dig;
   logic                    cur_dp, blank_cur;
   logic [7:0]              code;

   assign accept = load & ~conv_busy;

   bin2bcd_seq #(
      .NUM_DIGITS (NUM_DIGITS),
      .BIN_WIDTH  (BIN_WIDTH)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (bin_in),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Overflow decided at capture, but only made visible together with the digits
   always_comb begin
      ovf_pend_d = ovf_pend_q;
      if (accept) ovf_pend_d = ({{(32-BIN_WIDTH){1'b0}}, bin_in} >= OVF_LIMIT);
      digit_d = conv_done ? conv_bcd   : digit_q;
      ovf_d   = conv_done ? ovf_pend_q : ovf_q;
   end

   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      cur_dig = '0;
      cur_dp  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            cur_dig = digit_q[4*i +: 4];
            cur_dp  = dp_in[i];
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz;

   always_comb begin
      lz[NUM_DIGITS-1] = (digit_q[4*NUM_DIGITS-1 -: 4] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         lz[i] = lz[i+1] && (digit_q[4*i +: 4] == 4'd0);
      end
      blank_cur = 1'b0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_q) blank_cur = lz[i] && !ovf_q;
      end
   end
`else
   assign blank_cur = 1'b0;
`endif

   // Every code has bit7 set, so masking with the DP request yields the final pattern
   always_comb begin
      code = ovf_q ? SEG_DASH : bcd_to_seg(cur_dig);
      if (blank_cur) code = SEG_BLANK;
      if (enable) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_q);
         seg_d = code & {~cur_dp, 7'h7F};
      end else begin
         an_d  = '1;
         seg_d = SEG_BLANK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q    <= '0;
         idx_q      <= '0;
         digit_q    <= '0;
         ovf_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         digit_q    <= digit_d;
         ovf_q      <= ovf_d;
         ovf_pend_q <= ovf_pend_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign busy     = conv_busy;
   assign overflow = ovf_q;
   assign an_n     = an_q;
   assign seg_n    = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (NUM_DIGITS=4, BIN_WIDTH=14, SCAN_DIV=4).
// Expected digit codes follow the LEADING_ZERO_BLANK_EN build macro when it is defined.
module tb_seven_seg_scan_driver;

   localparam int ND = 4;
   localparam int BW = 14;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst, load, enable, busy, overflow;
   logic [BW-1:0] bin_in;
   logic [ND-1:0] dp_in, an_n;
   logic [7:0]    seg_n;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .NUM_DIGITS (ND),
      .BIN_WIDTH  (BW),
      .SCAN_DIV   (SD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bin_in   (bin_in),
      .load     (load),
      .busy     (busy),
      .enable   (enable),
      .dp_in    (dp_in),
      .an_n     (an_n),
      .seg_n    (seg_n),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] digit_code(input int v);
      case (v)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input int value, input int d, input logic dp);
      int         p;
      logic [7:0] code;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      code = (value >= 10000) ? 8'hBF : digit_code((value / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (value < 10000 && d > 0 && value < p) code = 8'hFF;
`endif
      return dp ? (code & 8'h7F) : code;
   endfunction

   task automatic start_load(input int value);
      @(negedge clk);
      bin_in = BW'(value);
      load   = 1'b1;
      exp_q.push_back(value);
      @(negedge clk);
      load   = 1'b0;
   endtask

   task automatic check_display(input string tag);
      int         value;
      int         guard;
      logic [3:0] tgt;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      value = exp_q.pop_front();
      @(negedge clk);
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, value >= 10000});
      for (int d = 0; d < ND; d++) begin
         tgt   = ~(4'b0001 << d);
         guard = 0;
         while (an_n !== tgt && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 40) chk($sformatf("%s_an_timeout%0d", tag, d), {28'd0, an_n}, {28'd0, tgt});
         else chk($sformatf("%s_seg%0d", tag, d), {24'd0, seg_n}, {24'd0, exp_seg(value, d, dp_in[d])});
      end
   endtask

   task automatic wait_done(input string tag, input int exp_len);
      int cnt;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk({tag, "_busy_len"}, cnt, exp_len);
      check_display(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] tgt;
      int         guard;
      rst = 1'b1; load = 1'b0; enable = 1'b1; dp_in = '0; bin_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf",  {31'd0, overflow}, 32'd0);
      chk("rst_an",   {28'd0, an_n}, 32'hF);
      chk("rst_seg",  {24'd0, seg_n}, 32'hFF);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      start_load(1234);
      wait_done("t1_1234", 15);

      start_load(9999);
      wait_done("t2_9999", 15);
      start_load(10000);
      wait_done("t2_10000", 15);

      // Scan order, hold time and per-digit decimal point
      dp_in = 4'b0100;
      guard = 0;
      while (an_n !== 4'b0111 && guard < 40) begin @(negedge clk); guard++; end
      while (an_n !== 4'b1110 && guard < 80) begin @(negedge clk); guard++; end
      chk("t3_sync", {31'd0, guard < 80}, 32'd1);
      for (int k = 0; k < 20; k++) begin
         tgt = ~(4'b0001 << ((k / 4) % 4));
         chk($sformatf("t3_an%0d", k), {28'd0, an_n}, {28'd0, tgt});
         chk($sformatf("t3_dp%0d", k), {31'd0, seg_n[7]}, {31'd0, ((k / 4) % 4) != 2});
         @(negedge clk);
      end
      dp_in  = '0;
      enable = 1'b0;
      @(negedge clk);
      chk("t3_blank_an",  {28'd0, an_n}, 32'hF);
      chk("t3_blank_seg", {24'd0, seg_n}, 32'hFF);
      enable = 1'b1;

      // Load while busy must be ignored
      start_load(42);
      repeat (2) @(negedge clk);
      bin_in = BW'(999);
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
      wait_done("t4_42", 12);
      repeat (3) @(negedge clk);
      chk("t4_no_restart", {31'd0, busy}, 32'd0);

      start_load(7);
      wait_done("t5_7", 15);
      start_load(0);
      wait_done("t5_0", 15);

      // Reset mid-conversion
      start_load(1234);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_an",   {28'd0, an_n}, 32'hF);
      chk("t6_seg",  {24'd0, seg_n}, 32'hFF);
      chk("t6_ovf",  {31'd0, overflow}, 32'd0);
      start_load(1234);
      wait_done("t6_reload", 15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
